// File: rtl/dct_transpose_buffer_pkg.sv
// Shared 8-point DCT definitions: block size, default element width and
// the packed-vector element placement used by every DCT stage.
package dct_transpose_buffer_pkg;

    localparam int unsigned DCT_PTS = 8;
    localparam int unsigned DCT_N   = 16;
    localparam int unsigned IDX_W   = $clog2(DCT_PTS);

    // Element idx of a packed vector sits at [elem_lsb(idx, n) +: n]; element 0 is at the MSB end.
    function automatic int unsigned elem_lsb(input int unsigned idx, input int unsigned n);
        return (DCT_PTS - 1 - idx) * n;
    endfunction

endpackage

// File: rtl/dct_transpose_buffer_bank.sv
// One 8x8 transpose bank: whole-row write port, combinational whole-column read port.
module transpose_bank
    import dct_transpose_buffer_pkg::*;
#(
    parameter int unsigned N = DCT_N
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [IDX_W-1:0]     row,
    input  logic [DCT_PTS*N-1:0] data,
    input  logic [IDX_W-1:0]     col,
    output logic [DCT_PTS*N-1:0] col_data_c
);

    // Storage is deliberately not reset; full flags in the parent gate its visibility.
    logic [N-1:0] mem [DCT_PTS][DCT_PTS];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int unsigned c = 0; c < DCT_PTS; c++) begin
                mem[row][IDX_W'(c)] <= data[elem_lsb(c, N) +: N];
            end
        end
    end

    always_comb begin
        col_data_c = '0;
        for (int unsigned r = 0; r < DCT_PTS; r++) begin
            col_data_c[elem_lsb(r, N) +: N] = mem[IDX_W'(r)][col];
        end
    end

endmodule

// File: rtl/dct_transpose_buffer.sv
// Ping-pong 8x8 transpose buffer between the row and column 1-D DCT passes:
// rows in, columns out, one bank filling while the other drains.
module dct_transpose_buffer
    import dct_transpose_buffer_pkg::*;
#(
    parameter int unsigned N = DCT_N
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DCT_PTS*N-1:0] in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DCT_PTS*N-1:0] out_data,
    output logic [IDX_W-1:0]     out_col,
    output logic                 out_last
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DCT_PTS - 1);

    logic [1:0]           full;
    logic [1:0]           full_d;
    logic                 wr_bank;
    logic                 rd_bank;
    logic [IDX_W-1:0]     wr_row;
    logic [IDX_W-1:0]     rd_col;
    logic                 wr_fire;
    logic                 rd_fire;
    logic [DCT_PTS*N-1:0] col0;
    logic [DCT_PTS*N-1:0] col1;

    // Handshakes depend only on registered flags/pointers.
    assign in_ready  = ~full[wr_bank];
    assign out_valid = full[rd_bank];
    assign wr_fire   = in_valid & in_ready;
    assign rd_fire   = out_valid & out_ready;

    assign out_data  = out_valid ? (rd_bank ? col1 : col0) : '0;
    assign out_col   = rd_col;
    assign out_last  = out_valid & (rd_col == LAST_IDX);

    transpose_bank #(.N(N)) u_bank0 (
        .clk        (clk),
        .we         (wr_fire & ~wr_bank),
        .row        (wr_row),
        .data       (in_data),
        .col        (rd_col),
        .col_data_c (col0)
    );

    transpose_bank #(.N(N)) u_bank1 (
        .clk        (clk),
        .we         (wr_fire & wr_bank),
        .row        (wr_row),
        .data       (in_data),
        .col        (rd_col),
        .col_data_c (col1)
    );

    // Fill and drain may complete in the same cycle; they always hit different banks.
    always_comb begin
        full_d = full;
        if (wr_fire && (wr_row == LAST_IDX)) begin
            full_d[wr_bank] = 1'b1;
        end
        if (rd_fire && (rd_col == LAST_IDX)) begin
            full_d[rd_bank] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            full    <= '0;
            wr_bank <= 1'b0;
            rd_bank <= 1'b0;
            wr_row  <= '0;
            rd_col  <= '0;
        end else begin
            full <= full_d;
            if (wr_fire) begin
                wr_row <= IDX_W'(wr_row + 1'b1);
                if (wr_row == LAST_IDX) begin
                    wr_bank <= ~wr_bank;
                end
            end
            if (rd_fire) begin
                rd_col <= IDX_W'(rd_col + 1'b1);
                if (rd_col == LAST_IDX) begin
                    rd_bank <= ~rd_bank;
                end
            end
        end
    end

endmodule

// File: tb/tb_dct_transpose_buffer.sv
// Self-checking bench for dct_transpose_buffer: a directed vector table plus
// randomized traffic checked against a queue-based transpose model.
module tb_dct_transpose_buffer;

    localparam int unsigned N = 16;
    localparam int unsigned W = 8 * N;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_data = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_data;
    logic [2:0]   out_col;
    logic         out_last;

    int checks = 0;
    int errors = 0;

    dct_transpose_buffer #(.N(N)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_col   (out_col),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         iv;
        logic [W-1:0] din;
        logic         ordy;
        logic         exp_ready;
        logic         exp_valid;
        logic [W-1:0] exp_data;
        logic [2:0]   exp_col;
        logic         exp_last;
    } vec_t;

    // Reference model: rows awaiting a full block, transposed columns awaiting drain.
    logic [W-1:0] src_q[$];
    logic [W-1:0] row_q[$];
    logic [W-1:0] col_q[$];
    int           accepted;
    int           not_ready_cycles;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] garbage();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [W-1:0] mk_row(input int r, input int kind);
        logic [W-1:0] v;
        logic [15:0]  e;
        v = '0;
        for (int c = 0; c < 8; c++) begin
            case (kind)
                0:       e = 16'(16 * r + c);
                1:       e = 16'h8000 | 16'(8 * r + c);
                2:       e = ((r + c) % 2 == 0) ? 16'hFFFF : 16'h8000;
                default: e = 16'($urandom);
            endcase
            v[(7 - c) * N +: N] = e;
        end
        return v;
    endfunction

    task automatic model_push_row(input logic [W-1:0] row);
        logic [W-1:0] col;
        logic [W-1:0] rw;
        row_q.push_back(row);
        if (row_q.size() == 8) begin
            for (int c = 0; c < 8; c++) begin
                col = '0;
                for (int r = 0; r < 8; r++) begin
                    rw = row_q[r];
                    col[(7 - r) * N +: N] = rw[(7 - c) * N +: N];
                end
                col_q.push_back(col);
            end
            row_q.delete();
        end
    endtask

    // One clock: drive, compare at the falling edge, advance model at the rising edge.
    task automatic step(input logic iv_en, input logic ordy);
        logic         e_ready;
        logic         e_valid;
        logic [W-1:0] e_data;
        logic [2:0]   e_col;
        int           pending;
        in_valid  = iv_en && (src_q.size() > 0);
        in_data   = in_valid ? src_q[0] : garbage();
        out_ready = ordy;
        @(negedge clk);
        pending = (col_q.size() + 7) / 8;
        e_ready = (pending < 2);
        e_valid = (col_q.size() > 0);
        e_data  = e_valid ? col_q[0] : '0;
        e_col   = 3'((8 - (col_q.size() % 8)) % 8);
        check("in_ready", W'(in_ready), W'(e_ready));
        check("out_valid", W'(out_valid), W'(e_valid));
        check("out_data", out_data, e_data);
        check("out_col", W'(out_col), W'(e_col));
        check("out_last", W'(out_last), W'(e_valid && (col_q.size() % 8 == 1)));
        if (!in_ready) not_ready_cycles++;
        @(posedge clk);
        if (e_valid && ordy) void'(col_q.pop_front());
        if (in_valid && e_ready) begin
            accepted++;
            model_push_row(src_q.pop_front());
        end
        #1;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((col_q.size() > 0 || src_q.size() > 0) && n < budget) begin
            step(1'b1, 1'b1);
            n++;
        end
        check("drain_timeout", W'(col_q.size() + src_q.size()), W'(0));
    endtask

    task automatic do_reset();
        in_valid  = 1'b1;
        in_data   = garbage();
        out_ready = 1'b0;
        reset     = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("rst_in_ready", W'(in_ready), W'(1));
            check("rst_out_valid", W'(out_valid), W'(0));
            check("rst_out_data", out_data, '0);
            check("rst_out_col", W'(out_col), W'(0));
            check("rst_out_last", W'(out_last), W'(0));
        end
        in_valid = 1'b0;
        reset    = 1'b1;
        src_q.delete();
        row_q.delete();
        col_q.delete();
        @(posedge clk);
        #1;
    endtask

    vec_t vecs[17];

    initial begin
        // Directed single block: rows 0..7 then 8 column reads, expectations from 16*r+c.
        for (int k = 0; k < 17; k++) begin
            logic [W-1:0] col;
            col = '0;
            for (int r = 0; r < 8; r++) col[(7 - r) * N +: N] = 16'(16 * r + (k - 8));
            vecs[k].iv        = (k < 8);
            vecs[k].din       = (k < 8) ? mk_row(k, 0) : garbage();
            vecs[k].ordy      = 1'b1;
            vecs[k].exp_ready = 1'b1;
            vecs[k].exp_valid = (k >= 8 && k < 16);
            vecs[k].exp_data  = (k >= 8 && k < 16) ? col : '0;
            vecs[k].exp_col   = (k >= 8 && k < 16) ? 3'(k - 8) : 3'd0;
            vecs[k].exp_last  = (k == 15);
        end
        accepted = 0;
        not_ready_cycles = 0;

        #2;
        do_reset();

        for (int k = 0; k < 17; k++) begin
            in_valid  = vecs[k].iv;
            in_data   = vecs[k].din;
            out_ready = vecs[k].ordy;
            @(negedge clk);
            check("tbl_in_ready", W'(in_ready), W'(vecs[k].exp_ready));
            check("tbl_out_valid", W'(out_valid), W'(vecs[k].exp_valid));
            check("tbl_out_data", out_data, vecs[k].exp_data);
            check("tbl_out_col", W'(out_col), W'(vecs[k].exp_col));
            check("tbl_out_last", W'(out_last), W'(vecs[k].exp_last));
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;

        // Back-pressure: 20 cycles of offered rows with out_ready low.
        for (int r = 0; r < 8; r++) src_q.push_back(mk_row(r, 0));
        for (int r = 0; r < 16; r++) src_q.push_back(mk_row(r, 3));
        accepted = 0;
        repeat (20) step(1'b1, 1'b0);
        check("bp_accepted", W'(accepted), W'(16));
        check("bp_in_ready", W'(in_ready), W'(0));
        begin
            logic [W-1:0] c0;
            c0 = '0;
            for (int r = 0; r < 8; r++) c0[(7 - r) * N +: N] = 16'(16 * r);
            check("bp_col0", out_data, c0);
        end
        src_q.delete();
        drain(40);

        // Streaming: 4 random blocks back to back.
        for (int r = 0; r < 32; r++) src_q.push_back(mk_row(r % 8, 3));
        not_ready_cycles = 0;
        accepted = 0;
        drain(60);
        check("stream_accepted", W'(accepted), W'(32));
        check("stream_no_stall", W'(not_ready_cycles), W'(0));

        // Random valid/ready traffic.
        for (int r = 0; r < 40; r++) src_q.push_back(mk_row(r % 8, 3));
        for (int i = 0; i < 150; i++) step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0));
        drain(100);

        // Reset after 5 rows: only the following block may appear.
        for (int r = 0; r < 5; r++) src_q.push_back(mk_row(r, 3));
        repeat (5) step(1'b1, 1'b1);
        do_reset();
        for (int r = 0; r < 8; r++) src_q.push_back(mk_row(r, 1));
        drain(40);

        // Sign corner patterns, drained with intermittent stalls.
        for (int r = 0; r < 8; r++) src_q.push_back(mk_row(r, 2));
        repeat (12) step(1'b1, 1'b0);
        for (int i = 0; i < 30; i++) step(1'b1, 1'(i % 3 != 1));
        drain(40);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
